iscas_resp_misr: RTL and testbench

//   Response compactor on the output side of an ISCAS-85 combinational benchmark (c499: 32 outputs).

---
 rtl/iscas_resp_misr.sv | 127 ++++++++++++
 tb/tb_iscas_resp_misr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/iscas_resp_misr.sv
// iscas_resp_misr: MISR response compactor for ISCAS-85 benchmark outputs.
// Optional golden compare (pass/fail) enabled by defining GOLDEN_CMP_EN.
module iscas_resp_misr #(
  parameter int OUT_WIDTH = 32,
  parameter int VEC_LENGTH = 31,
  parameter logic [OUT_WIDTH-1:0] POLY = 32'h04C1_1DB7,
  parameter logic [OUT_WIDTH-1:0] SEED = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 resp_valid,
  input  logic [OUT_WIDTH-1:0] resp_data,
`ifdef GOLDEN_CMP_EN
  input  logic [OUT_WIDTH-1:0] golden_sig,
  output logic                 pass,
  output logic                 fail,
`endif
  output logic [OUT_WIDTH-1:0] signature,
  output logic [15:0]          vec_count,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(VEC_LENGTH - 1);

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] sig_q, sig_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 load, accept, last;
  logic [OUT_WIDTH-1:0] misr;

  assign load   = start && (state_q != S_RUN);
  assign accept = resp_valid && (state_q == S_RUN);
  assign last   = (cnt_q == LAST);
  assign misr   = {sig_q[OUT_WIDTH-2:0], 1'b0}
                ^ (sig_q[OUT_WIDTH-1] ? POLY : '0)
                ^ resp_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && last) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Signature and count next values: reload on start, fold on accept
  always_comb begin
    sig_d = sig_q;
    cnt_d = cnt_q;
    if (load) begin
      sig_d = SEED;
      cnt_d = '0;
    end else if (accept) begin
      sig_d = misr;
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Signature and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
      cnt_q <= '0;
    end else begin
      sig_q <= sig_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    signature = sig_q;
    vec_count = cnt_q;
  end

`ifdef GOLDEN_CMP_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;

  // Verdict latched when DONE is entered, cleared on leaving it
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (state_q == S_RUN && state_d == S_DONE) begin
      pass_d = (sig_d == golden_sig);
      fail_d = (sig_d != golden_sig);
    end else if (state_d != S_DONE) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end
  end

  // Verdict registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_iscas_resp_misr.sv
// tb_iscas_resp_misr: scoreboard bench for iscas_resp_misr.
// Covers default build and GOLDEN_CMP_EN build.
module tb_iscas_resp_misr;

  localparam logic [31:0] POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] SEED4 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, start, resp_valid;
  logic [31:0] resp_data, golden_sig;
  logic [31:0] sig, sig4;
  logic [15:0] cnt, cnt4;
  logic        busy, done, busy4, done4;
  logic        pass, fail, pass4, fail4;

  always #5 clk = ~clk;

  iscas_resp_misr dut (
    .clk(clk), .rst(rst), .start(start),
    .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef GOLDEN_CMP_EN
    .golden_sig(golden_sig), .pass(pass), .fail(fail),
`endif
    .signature(sig), .vec_count(cnt),
    .busy(busy), .done(done)
  );

  iscas_resp_misr #(.SEED(SEED4)) dut4 (
    .clk(clk), .rst(rst), .start(start),
    .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef GOLDEN_CMP_EN
    .golden_sig(golden_sig), .pass(pass4), .fail(fail4),
`endif
    .signature(sig4), .vec_count(cnt4),
    .busy(busy4), .done(done4)
  );

`ifndef GOLDEN_CMP_EN
  assign pass = 1'b0;
  assign fail = 1'b0;
  assign pass4 = 1'b0;
  assign fail4 = 1'b0;
`endif

  typedef struct {
    logic [31:0] sig;
    logic [31:0] sig4;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // model state: 0 idle, 1 run, 2 done
  int          ms = 0;
  logic [31:0] msg = '0, msg4 = SEED4;
  logic [15:0] mcn = '0;
  logic        mp = 0, mf = 0;

  logic [31:0] vecs[31];
  logic [31:0] final_sig;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fold(logic [31:0] s,
                                       logic [31:0] d);
    logic [31:0] r;
    r = s << 1;
    if (s[31]) r = r ^ POLY;
    return r ^ d;
  endfunction

  task automatic step(input logic r, input logic s,
                      input logic v, input logic [31:0] d);
    exp_t e;
    rst = r; start = s; resp_valid = v; resp_data = d;
    if (r) begin
      ms = 0; msg = '0; msg4 = SEED4; mcn = '0;
      mp = 0; mf = 0;
    end else if (ms == 0) begin
      if (s) begin
        ms = 1; msg = '0; msg4 = SEED4; mcn = '0;
      end
    end else if (ms == 1) begin
      if (v) begin
        msg = fold(msg, d);
        msg4 = fold(msg4, d);
        mcn = mcn + 1;
        if (mcn == 16'd31) begin
          ms = 2;
          mp = (msg == golden_sig);
          mf = !mp;
        end
      end
    end else if (s) begin
      ms = 1; msg = '0; msg4 = SEED4; mcn = '0;
      mp = 0; mf = 0;
    end
    e.sig = msg; e.sig4 = msg4; e.cnt = mcn;
    e.busy = (ms == 1); e.done = (ms == 2);
    e.pass = mp; e.fail = mf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sig", sig, e.sig);
    chk("sig4", sig4, e.sig4);
    chk("cnt", cnt, e.cnt);
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
`ifdef GOLDEN_CMP_EN
    chk("pass", pass, e.pass);
    chk("fail", fail, e.fail);
`endif
  endtask

  task automatic run_vecs();
    step(0, 1, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 31; i++) begin
      if (i % 4 == 2) step(0, 0, 0, $urandom);
      if (i == 5) step(0, 1, 1, vecs[i]);
      else step(0, 0, 1, vecs[i]);
    end
  endtask

  initial begin
    rst = 1; start = 0; resp_valid = 0;
    resp_data = '0; golden_sig = '0;
    for (int i = 0; i < 31; i++) vecs[i] = $urandom;

    // reset
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    step(0, 0, 1, 32'h1234_5678);
    chk("rst_sig", sig, 32'h0);
    chk("rst_cnt", cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // 31 zero vectors
    step(0, 1, 0, '0);
    for (int i = 0; i < 31; i++) step(0, 0, 1, '0);
    chk("zero_done", done, 1'b1);
    chk("zero_cnt", cnt, 16'd31);
    chk("zero_sig", sig, 32'h0);
    step(0, 0, 1, 32'hDEAD_BEEF);
    chk("done_hold", sig, 32'h0);

    // shift path and feedback path
    step(0, 1, 0, '0);
    step(0, 0, 1, 32'h1);
    chk("shift1", sig, 32'h1);
    chk("fb4", sig4, POLY ^ 32'h1);
    step(0, 0, 1, 32'h0);
    chk("shift2", sig, 32'h2);
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    step(0, 0, 1, 32'h0);
    chk("fb_only", sig4, POLY);

    // gaps, mid-run start, reset at vector 10
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    for (int i = 0; i < 10; i++) begin
      step(0, i == 3, 1, vecs[i]);
      step(0, 0, 0, $urandom);
    end
    chk("mid_cnt", cnt, 16'd10);
    step(1, 0, 1, vecs[10]);
    chk("rst_mid_cnt", cnt, 16'd0);
    chk("rst_mid_busy", busy, 1'b0);

    // random run with mismatching golden
    golden_sig = 32'h0;
    run_vecs();
    chk("rand_done", done, 1'b1);
    final_sig = msg;

    // matching golden
    golden_sig = final_sig;
    run_vecs();
    chk("match_sig", sig, final_sig);

    // one bit flipped
    golden_sig = final_sig ^ 32'h0000_0100;
    run_vecs();
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
